// File: rtl/program_sequencer.sv
// program_sequencer
//   Next-PC unit for the microprocessor core. Owns the PC, the previous PC and a
//   hardware return-address stack. Resolves the next PC from the decoded flow op
//   (jumps, conditional branches, call/return) and implements the blocking
//   switch-input wait (IN) and the delay wait (DELAY).
//
//   Optional feature macro: SEQ_STACK_GUARD_EN
//     defined   : CALL on a full stack or RET on an empty stack sets the sticky
//                 stack_err flag and halts the core (stall=1) until reset.
//     undefined : stack_err is tied 0; CALL on full overwrites the top entry,
//                 RET on empty jumps to address 0.
//
// Ports
//   clk         core clock, all logic on posedge
//   reset       synchronous, active-high
//   op          flow op: 0 NEXT,1 JMP_IMM,2 JMP_REG,3 BR_IMM,4 BR_REG,5 CALL,
//               6 RET,7 IN,8 DELAY; 9-15 behave as NEXT
//   cond        branch condition (compare flag), sampled with op
//   imm_target  absolute target from the instruction field
//   reg_target  target from the jump register
//   ent         asynchronous enter button, active-low
//   switch_in   switch bank
//   delay_busy  delay counter running
//   pc          current PC
//   last_pc     PC of the previously executed instruction
//   sw_data     switch value latched by IN
//   sw_valid    1-cycle pulse when sw_data updates
//   stall       1 while IN/DELAY hold the PC (and while halted on a stack fault)
//   sp          stack occupancy
//   stack_full  sp == STACK_DEPTH
//   stack_empty sp == 0
//   stack_err   sticky stack fault (0 when the guard is not built)

module program_sequencer #(
   parameter int unsigned PC_W        = 16,
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned SW_W        = 16,
   parameter int unsigned ENT_SYNC    = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [3:0]                         op,
   input  logic                               cond,
   input  logic [PC_W-1:0]                    imm_target,
   input  logic [PC_W-1:0]                    reg_target,
   input  logic                               ent,
   input  logic [SW_W-1:0]                    switch_in,
   input  logic                               delay_busy,
   output logic [PC_W-1:0]                    pc,
   output logic [PC_W-1:0]                    last_pc,
   output logic [SW_W-1:0]                    sw_data,
   output logic                               sw_valid,
   output logic                               stall,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               stack_err
);

   localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

   typedef enum logic [2:0] {
      S_RUN,
      S_IN_PRESS,
      S_IN_REL,
      S_DLY_WAIT,
      S_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_NEXT    = 4'd0,
      OP_JMP_IMM = 4'd1,
      OP_JMP_REG = 4'd2,
      OP_BR_IMM  = 4'd3,
      OP_BR_REG  = 4'd4,
      OP_CALL    = 4'd5,
      OP_RET     = 4'd6,
      OP_IN      = 4'd7,
      OP_DELAY   = 4'd8
   } op_t;

   state_t              state, state_n;
   logic [PC_W-1:0]     pc_n, pc_inc;
   logic                pc_load;
   logic [SP_W-1:0]     sp_n;
   logic                push;
   logic                sw_latch;
   logic [IDX_W-1:0]    wr_idx, rd_idx;
   logic [ENT_SYNC-1:0] ent_sync;
   logic                ent_s;
   logic [PC_W-1:0]     stack [STACK_DEPTH];

`ifdef SEQ_STACK_GUARD_EN
   logic                err_set;
   logic                err_q;
`endif

   assign pc_inc      = pc + PC_W'(1);
   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   // A CALL on a full stack reuses the top slot instead of indexing past it.
   assign wr_idx      = stack_full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(sp);
   assign rd_idx      = IDX_W'(sp - SP_W'(1));
   assign ent_s       = ent_sync[ENT_SYNC-1];

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      pc_load  = 1'b0;
      sp_n     = sp;
      push     = 1'b0;
      sw_latch = 1'b0;
      stall    = (state != S_RUN);
`ifdef SEQ_STACK_GUARD_EN
      err_set  = 1'b0;
`endif
      case (state)
         S_RUN: begin
            case (op)
               OP_JMP_IMM: begin
                  pc_n    = imm_target;
                  pc_load = 1'b1;
               end
               OP_JMP_REG: begin
                  pc_n    = reg_target;
                  pc_load = 1'b1;
               end
               OP_BR_IMM: begin
                  pc_n    = cond ? imm_target : pc_inc;
                  pc_load = 1'b1;
               end
               OP_BR_REG: begin
                  pc_n    = cond ? reg_target : pc_inc;
                  pc_load = 1'b1;
               end
               OP_CALL: begin
`ifdef SEQ_STACK_GUARD_EN
                  if (stack_full) begin
                     err_set = 1'b1;
                     state_n = S_HALT;
                     stall   = 1'b1;
                  end else
`endif
                  begin
                     push    = 1'b1;
                     pc_n    = imm_target;
                     pc_load = 1'b1;
                     if (!stack_full) sp_n = sp + SP_W'(1);
                  end
               end
               OP_RET: begin
`ifdef SEQ_STACK_GUARD_EN
                  if (stack_empty) begin
                     err_set = 1'b1;
                     state_n = S_HALT;
                     stall   = 1'b1;
                  end else
`endif
                  begin
                     pc_load = 1'b1;
                     if (stack_empty) begin
                        pc_n = '0;
                     end else begin
                        pc_n = stack[rd_idx];
                        sp_n = sp - SP_W'(1);
                     end
                  end
               end
               OP_IN: begin
                  state_n = S_IN_PRESS;
                  stall   = 1'b1;
               end
               OP_DELAY: begin
                  state_n = S_DLY_WAIT;
                  stall   = 1'b1;
               end
               default: begin
                  pc_n    = pc_inc;
                  pc_load = 1'b1;
               end
            endcase
         end
         S_IN_PRESS: begin
            if (!ent_s) state_n = S_IN_REL;
         end
         S_IN_REL: begin
            if (ent_s) begin
               sw_latch = 1'b1;
               pc_n     = pc_inc;
               pc_load  = 1'b1;
               state_n  = S_RUN;
            end
         end
         S_DLY_WAIT: begin
            if (!delay_busy) begin
               pc_n    = pc_inc;
               pc_load = 1'b1;
               state_n = S_RUN;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RUN;
         pc       <= '0;
         last_pc  <= '0;
         sp       <= '0;
         sw_data  <= '0;
         sw_valid <= 1'b0;
         ent_sync <= '1;
      end else begin
         state    <= state_n;
         sp       <= sp_n;
         sw_valid <= sw_latch;
         ent_sync <= {ent_sync[ENT_SYNC-2:0], ent};
         if (pc_load) begin
            pc      <= pc_n;
            last_pc <= pc;
         end
         if (sw_latch) sw_data <= switch_in;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) stack[wr_idx] <= pc_inc;
   end

`ifdef SEQ_STACK_GUARD_EN
   always_ff @(posedge clk) begin
      if (reset)        err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end
   assign stack_err = err_q;
`else
   assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer
//   Directed bench for program_sequencer (default parameters). A table of flow
//   ops with hand-computed pc/last_pc/sp is applied one op per cycle, followed
//   by hand-written sequences for IN, DELAY, reset during a wait and stack
//   overflow/underflow. Expectations follow SEQ_STACK_GUARD_EN when defined.

module tb_program_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  op;
   logic        cond;
   logic [15:0] imm_target;
   logic [15:0] reg_target;
   logic        ent;
   logic [15:0] switch_in;
   logic        delay_busy;
   logic [15:0] pc;
   logic [15:0] last_pc;
   logic [15:0] sw_data;
   logic        sw_valid;
   logic        stall;
   logic [3:0]  sp;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_err;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   program_sequencer #(
      .PC_W(16),
      .STACK_DEPTH(8),
      .SW_W(16),
      .ENT_SYNC(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .op(op),
      .cond(cond),
      .imm_target(imm_target),
      .reg_target(reg_target),
      .ent(ent),
      .switch_in(switch_in),
      .delay_busy(delay_busy),
      .pc(pc),
      .last_pc(last_pc),
      .sw_data(sw_data),
      .sw_valid(sw_valid),
      .stall(stall),
      .sp(sp),
      .stack_full(stack_full),
      .stack_empty(stack_empty),
      .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        cond;
      logic [15:0] imm;
      logic [15:0] rgt;
      logic [15:0] exp_pc;
      logic [15:0] exp_last;
      logic [3:0]  exp_sp;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (sw_valid === 1'b1) got = 1'b1;
      end
      check(name, {31'd0, got}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit got;

      //           op    cond  imm       reg       pc        last      sp
      tbl[0]  = '{4'd0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 4'd0};
      tbl[1]  = '{4'd0, 1'b0, 16'h0000, 16'h0000, 16'h0002, 16'h0001, 4'd0};
      tbl[2]  = '{4'd0, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'h0002, 4'd0};
      tbl[3]  = '{4'd1, 1'b0, 16'h0005, 16'h0000, 16'h0005, 16'h0003, 4'd0};
      tbl[4]  = '{4'd3, 1'b0, 16'h0020, 16'h0000, 16'h0006, 16'h0005, 4'd0};
      tbl[5]  = '{4'd1, 1'b0, 16'h0005, 16'h0000, 16'h0005, 16'h0006, 4'd0};
      tbl[6]  = '{4'd3, 1'b1, 16'h0020, 16'h0000, 16'h0020, 16'h0005, 4'd0};
      tbl[7]  = '{4'd4, 1'b1, 16'h0000, 16'h0040, 16'h0040, 16'h0020, 4'd0};
      tbl[8]  = '{4'd4, 1'b0, 16'h0000, 16'h0099, 16'h0041, 16'h0040, 4'd0};
      tbl[9]  = '{4'd2, 1'b0, 16'h0000, 16'h0003, 16'h0003, 16'h0041, 4'd0};
      tbl[10] = '{4'd5, 1'b0, 16'h0010, 16'h0000, 16'h0010, 16'h0003, 4'd1};
      tbl[11] = '{4'd6, 1'b0, 16'h0000, 16'h0000, 16'h0004, 16'h0010, 4'd0};
      tbl[12] = '{4'd12, 1'b1, 16'h0077, 16'h0088, 16'h0005, 16'h0004, 4'd0};
      tbl[13] = '{4'd1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0005, 4'd0};
      tbl[14] = '{4'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 4'd0};
      tbl[15] = '{4'd5, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 4'd1};
      tbl[16] = '{4'd5, 1'b0, 16'h0100, 16'h0000, 16'h0100, 16'hFFFF, 4'd2};
      tbl[17] = '{4'd6, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1};
      tbl[18] = '{4'd6, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 4'd0};

      reset = 1'b1; op = 4'd0; cond = 1'b0; imm_target = '0; reg_target = '0;
      ent = 1'b1; switch_in = '0; delay_busy = 1'b0;
      tick(); tick();
      check("rst_pc", pc, 0);
      check("rst_last_pc", last_pc, 0);
      check("rst_sp", sp, 0);
      check("rst_sw_data", sw_data, 0);
      check("rst_sw_valid", sw_valid, 0);
      check("rst_stall", stall, 0);
      check("rst_stack_err", stack_err, 0);
      check("rst_empty", stack_empty, 1);
      check("rst_full", stack_full, 0);
      reset = 1'b0;

      // Table of single-cycle flow ops, each applied from the state left by the previous one.
      for (int i = 0; i < 19; i++) begin
         op = tbl[i].op; cond = tbl[i].cond;
         imm_target = tbl[i].imm; reg_target = tbl[i].rgt;
         tick();
         check($sformatf("v%0d_pc", i), pc, tbl[i].exp_pc);
         check($sformatf("v%0d_last_pc", i), last_pc, tbl[i].exp_last);
         check($sformatf("v%0d_sp", i), sp, tbl[i].exp_sp);
         check($sformatf("v%0d_empty", i), stack_empty, (tbl[i].exp_sp == 0));
         check($sformatf("v%0d_stall", i), stall, 0);
      end
      cond = 1'b0;

      // IN: button released while waiting, then a full press/release.
      op = 4'd7; switch_in = 16'hBEEF; ent = 1'b1;
      #1 check("in_entry_stall", stall, 1);
      tick();
      op = 4'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("in_hold_pc", pc, 16'h0001);
         check("in_hold_stall", stall, 1);
      end
      ent = 1'b0;
      tick(); tick(); tick();
      check("in_press_pc", pc, 16'h0001);
      ent = 1'b1;
      wait_valid("in_valid", got);
      check("in_sw_data", sw_data, 16'hBEEF);
      check("in_pc", pc, 16'h0002);
      check("in_last_pc", last_pc, 16'h0001);
      check("in_stall_clr", stall, 0);

      // IN with the button already pressed when the wait starts.
      op = 4'd1; imm_target = 16'h0002; ent = 1'b0; switch_in = 16'h1234;
      tick();
      check("in_pulse_end", sw_valid, 0);
      check("in_hold_data", sw_data, 16'hBEEF);
      tick();
      op = 4'd7;
      tick();
      op = 4'd0; ent = 1'b1;
      wait_valid("in2_valid", got);
      check("in2_sw_data", sw_data, 16'h1234);
      check("in2_pc", pc, 16'h0003);

      // DELAY with delay_busy low: exactly two cycles.
      op = 4'd8; delay_busy = 1'b0;
      #1 check("dly_entry_stall", stall, 1);
      tick();
      op = 4'd0;
      check("dly_c1_pc", pc, 16'h0003);
      check("dly_c1_stall", stall, 1);
      tick();
      check("dly_c2_pc", pc, 16'h0004);
      check("dly_c2_last_pc", last_pc, 16'h0003);
      check("dly_c2_stall", stall, 0);

      // DELAY held by delay_busy for 10 cycles.
      op = 4'd8; delay_busy = 1'b1;
      tick();
      op = 4'd0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("dly_busy_pc", pc, 16'h0004);
         check("dly_busy_stall", stall, 1);
      end
      delay_busy = 1'b0;
      tick();
      check("dly_done_pc", pc, 16'h0005);
      check("dly_done_stall", stall, 0);

      // Reset while a switch latch is pending in the release wait.
      op = 4'd7; ent = 1'b0; switch_in = 16'hAAAA;
      tick();
      op = 4'd0;
      tick(); tick(); tick();
      ent = 1'b1;
      reset = 1'b1;
      tick();
      check("rw_pc", pc, 0);
      check("rw_last_pc", last_pc, 0);
      check("rw_sw_data", sw_data, 0);
      check("rw_sw_valid", sw_valid, 0);
      check("rw_stall", stall, 0);
      reset = 1'b0;
      tick();
      check("rw_run_pc", pc, 16'h0001);
      check("rw_no_latch", sw_valid, 0);
      check("rw_data_kept", sw_data, 0);

      // Stack: STACK_DEPTH+1 nested CALLs.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         op = 4'd5; imm_target = 16'h0100 + 16'(i);
         tick();
      end
      check("stk8_sp", sp, 8);
      check("stk8_full", stack_full, 1);
      check("stk8_pc", pc, 16'h0107);
      op = 4'd5; imm_target = 16'h0108;
      tick();
`ifdef SEQ_STACK_GUARD_EN
      op = 4'd0;
      check("ovf_err", stack_err, 1);
      check("ovf_pc", pc, 16'h0107);
      check("ovf_sp", sp, 8);
      check("ovf_stall", stall, 1);
      tick(); tick(); tick();
      check("ovf_frozen_pc", pc, 16'h0107);
      check("ovf_sticky_err", stack_err, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("ovf_rst_err", stack_err, 0);
      check("ovf_rst_pc", pc, 0);
      op = 4'd6;
      tick();
      op = 4'd0;
      check("unf_err", stack_err, 1);
      check("unf_sp", sp, 0);
      check("unf_stall", stall, 1);
      tick(); tick();
      check("unf_frozen_pc", pc, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("unf_rst_err", stack_err, 0);
`else
      check("ovf_err", stack_err, 0);
      check("ovf_pc", pc, 16'h0108);
      check("ovf_sp", sp, 8);
      op = 4'd6;
      tick();
      check("ret_newest_pc", pc, 16'h0108);
      check("ret_newest_sp", sp, 7);
      for (int i = 0; i < 6; i++) tick();
      check("ret7_pc", pc, 16'h0101);
      tick();
      check("ret_oldest_pc", pc, 16'h0001);
      check("ret_oldest_sp", sp, 0);
      tick();
      check("unf_pc", pc, 0);
      check("unf_last_pc", last_pc, 16'h0001);
      check("unf_sp", sp, 0);
      check("unf_err", stack_err, 0);
      op = 4'd0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
